// File: rtl/enc_engine_param.sv
// enc_engine_param: two-stage valid/ready encrypter with key/salt LFSRs.
// Optional run-time seeding ports are enabled by defining ENC_SEED_LOAD_EN.
module enc_engine_param #(
  parameter int DATA_W = 60,
  parameter int KEY_W = 11,
  parameter int SALT_W = 6,
  parameter int NUM_MODES = 4,
  parameter logic [KEY_W-1:0] KEY_SEED = 11'h5A5,
  parameter logic [SALT_W-1:0] SALT_SEED = 6'h2B,
  localparam int MODE_W = $clog2(NUM_MODES),
  localparam int OUT_W = DATA_W + KEY_W + SALT_W + MODE_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
`ifdef ENC_SEED_LOAD_EN
  ,
  input  logic              seed_load,
  input  logic [KEY_W-1:0]  seed_key,
  input  logic [SALT_W-1:0] seed_salt
`endif
);

  typedef enum logic {EMPTY, FULL} st_e;

  // Maximal-length feedback taps, bit (n-1) set for term x^n.
  function automatic logic [31:0] taps(input int w);
    case (w)
      2:       taps = 32'h0003;
      3:       taps = 32'h0006;
      4:       taps = 32'h000C;
      5:       taps = 32'h0014;
      6:       taps = 32'h0030;
      7:       taps = 32'h0060;
      8:       taps = 32'h00B8;
      9:       taps = 32'h0110;
      10:      taps = 32'h0240;
      11:      taps = 32'h0500;
      12:      taps = 32'h0829;
      13:      taps = 32'h100D;
      14:      taps = 32'h2015;
      15:      taps = 32'h6000;
      16:      taps = 32'hD008;
      default: taps = 32'h3 << (w - 2);
    endcase
  endfunction

  localparam logic [31:0] KEY_TAPS = taps(KEY_W);
  localparam logic [31:0] SALT_TAPS = taps(SALT_W);
  localparam logic [KEY_W-1:0] KEY_MASK = KEY_TAPS[KEY_W-1:0];
  localparam logic [SALT_W-1:0] SALT_MASK = SALT_TAPS[SALT_W-1:0];

  function automatic logic [KEY_W-1:0] key_step(
    input logic [KEY_W-1:0] s
  );
    if (s == '0) key_step = KEY_W'(1);
    else key_step = {s[KEY_W-2:0], ^(s & KEY_MASK)};
  endfunction

  function automatic logic [SALT_W-1:0] salt_step(
    input logic [SALT_W-1:0] s
  );
    if (s == '0) salt_step = SALT_W'(1);
    else salt_step = {s[SALT_W-2:0], ^(s & SALT_MASK)};
  endfunction

  function automatic logic [DATA_W-1:0] rep_key(
    input logic [KEY_W-1:0] k
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = k[i % KEY_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rep_salt(
    input logic [SALT_W-1:0] s
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = s[i % SALT_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] bitrev(
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  st_e s1_st_q, s1_st_d;
  st_e s2_st_q, s2_st_d;
  logic rdy_q;
  logic [KEY_W-1:0] key_q, key_d;
  logic [SALT_W-1:0] salt_q, salt_d;
  logic [DATA_W-1:0] s1_data_q;
  logic [KEY_W-1:0] s1_key_q;
  logic [SALT_W-1:0] s1_salt_q;
  logic [OUT_W-1:0] out_q, out_d;

  logic s1_load, s2_load, accept;

  always_comb begin
    s2_load = (s2_st_q == EMPTY) | out_ready;
    s1_load = (s1_st_q == EMPTY) | s2_load;
    in_ready = rdy_q & s1_load;
    accept = in_valid & in_ready;
    s1_st_d = s1_st_q;
    s2_st_d = s2_st_q;
    if (s2_load) s2_st_d = (s1_st_q == FULL) ? FULL : EMPTY;
    if (s1_load) s1_st_d = accept ? FULL : EMPTY;
  end

  // A seed load overrides the step taken by a simultaneous accept.
  always_comb begin
    key_d = key_q;
    salt_d = salt_q;
    if (accept) begin
      key_d = key_step(key_q);
      salt_d = salt_step(salt_q);
    end
`ifdef ENC_SEED_LOAD_EN
    if (seed_load) begin
      key_d = seed_key;
      salt_d = seed_salt;
    end
`endif
  end

  logic [MODE_W-1:0] mode;
  logic [31:0] rot;
  logic [DATA_W-1:0] kx, sx, dat, enc;
  logic [2*DATA_W-1:0] dbl;

  always_comb begin
    mode = s1_salt_q[MODE_W-1:0];
    kx = rep_key(s1_key_q);
    sx = rep_salt(s1_salt_q);
    rot = 32'(s1_salt_q) % 32'(DATA_W);
    dbl = '0;
    dat = s1_data_q;
    unique case (1'b1)
      (32'(mode) == 1): begin
        dbl = {s1_data_q, s1_data_q} << rot;
        dat = dbl[2*DATA_W-1:DATA_W];
      end
      (32'(mode) == 2): dat = bitrev(s1_data_q);
      (32'(mode) == 3): begin
        dbl = {2{s1_data_q ^ sx}} >> rot;
        dat = dbl[DATA_W-1:0];
      end
      default: dat = s1_data_q;
    endcase
    enc = dat ^ kx;
    out_d = out_q;
    if (s2_load && s1_st_q == FULL) begin
      out_d = {mode, s1_salt_q, s1_key_q, enc};
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_st_q <= EMPTY;
      s2_st_q <= EMPTY;
      rdy_q <= 1'b0;
      key_q <= KEY_SEED;
      salt_q <= SALT_SEED;
      s1_data_q <= '0;
      s1_key_q <= '0;
      s1_salt_q <= '0;
      out_q <= '0;
    end else begin
      s1_st_q <= s1_st_d;
      s2_st_q <= s2_st_d;
      rdy_q <= 1'b1;
      key_q <= key_d;
      salt_q <= salt_d;
      out_q <= out_d;
      if (accept) begin
        s1_data_q <= in_data;
        s1_key_q <= key_q;
        s1_salt_q <= salt_q;
      end
    end
  end

  assign out_valid = (s2_st_q == FULL);
  assign out_data = out_q;

endmodule

// File: tb/tb_enc_engine_param.sv
// Scoreboard bench for enc_engine_param at default parameters.
// Seed-load vectors run only when ENC_SEED_LOAD_EN is defined.
module tb_enc_engine_param;

  logic Clk = 1'b0;
  logic Rst;
  logic in_valid;
  logic in_ready;
  logic [59:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [78:0] out_data;
`ifdef ENC_SEED_LOAD_EN
  logic seed_load;
  logic [10:0] seed_key;
  logic [5:0] seed_salt;
`endif

  enc_engine_param dut (
    .Clk(Clk),
    .Rst(Rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef ENC_SEED_LOAD_EN
    ,
    .seed_load(seed_load),
    .seed_key(seed_key),
    .seed_salt(seed_salt)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [78:0] sb[$];
  logic [10:0] km;
  logic [5:0] sm;
  int ready_mode = 0;
  logic held_v = 1'b0;
  logic [78:0] held;
  logic [78:0] exp_v;

  function automatic logic [78:0] model(
    input logic [59:0] d,
    input logic [10:0] k,
    input logic [5:0] s
  );
    logic [59:0] kr, sr, t, e;
    int r;
    for (int i = 0; i < 60; i++) begin
      kr[i] = k[i % 11];
      sr[i] = s[i % 6];
    end
    r = int'(s) % 60;
    e = '0;
    case (s[1:0])
      2'd0: e = d;
      2'd1: for (int i = 0; i < 60; i++) e[(i + r) % 60] = d[i];
      2'd2: for (int i = 0; i < 60; i++) e[i] = d[59 - i];
      default: begin
        t = d ^ sr;
        for (int i = 0; i < 60; i++) e[i] = t[(i + r) % 60];
      end
    endcase
    return {s[1:0], s, k, e ^ kr};
  endfunction

  task automatic step_model();
    km = (km == 11'd0) ? 11'd1 : {km[9:0], km[10] ^ km[8]};
    sm = (sm == 6'd0) ? 6'd1 : {sm[4:0], sm[5] ^ sm[4]};
  endtask

  task automatic check(input string nm, input logic [78:0] act,
                       input logic [78:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic send_core(input logic [59:0] d, input logic hand,
                           input logic [78:0] hexp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    forever begin
      @(negedge Clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck 0 for data %h", d);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(hand ? hexp : model(d, km, sm));
    step_model();
    @(posedge Clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [59:0] d);
    send_core(d, 1'b0, '0);
  endtask

  task automatic send_hand(input logic [59:0] d, input logic [78:0] e);
    send_core(d, 1'b1, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge Clk);
      n++;
    end
    @(posedge Clk);
    #1;
    check("drain_queue_empty", 79'(sb.size()), 79'(0));
    check("drain_out_valid", 79'(out_valid), 79'(0));
  endtask

`ifdef ENC_SEED_LOAD_EN
  task automatic seed(input logic [10:0] k, input logic [5:0] s);
    seed_key = k;
    seed_salt = s;
    seed_load = 1'b1;
    @(posedge Clk);
    #1 seed_load = 1'b0;
    km = k;
    sm = s;
  endtask
`endif

  always @(posedge Clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge Clk) begin
    if (Rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        if (!out_valid || out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h expected %h",
                   out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h expected none", out_data);
        end else begin
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL beat: got %h expected %h", out_data, exp_v);
          end
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held = out_data;
      end
    end
  end

  logic [59:0] vec[12] = '{
    60'h123456789ABCDEF, 60'h000000000000000, 60'hFFFFFFFFFFFFFFF,
    60'h000000000000001, 60'h800000000000000, 60'hA5A5A5A5A5A5A5A,
    60'h5A5A5A5A5A5A5A5, 60'h0F0F0F0F0F0F0F0, 60'hDEADBEEFCAFE123,
    60'h00000000000FFFF, 60'hFFFF00000000000, 60'h13579BDF2468ACE
  };

  initial begin
    logic [59:0] d;
    Rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
`ifdef ENC_SEED_LOAD_EN
    seed_load = 1'b0;
    seed_key = '0;
    seed_salt = '0;
`endif
    km = 11'h5A5;
    sm = 6'h2B;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_out_valid", 79'(out_valid), 79'(0));
    check("rst_out_data", out_data, 79'(0));
    check("rst_in_ready", 79'(in_ready), 79'(0));
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("in_ready_after_rst", 79'(in_ready), 79'(1));

    send(vec[0]);
    check("stage1_only_out_valid", 79'(out_valid), 79'(0));
    for (int i = 1; i < 12; i++) send(vec[i]);
    drain();

`ifdef ENC_SEED_LOAD_EN
    seed(11'd0, 6'd0);
    send_hand(60'h123456789ABCDEF,
              {2'd0, 6'd0, 11'd0, 60'h123456789ABCDEF});
    seed(11'd0, 6'd5);
    send_hand(60'h1, {2'd1, 6'd5, 11'd0, 60'h20});
    send(60'h1);
    seed(11'd0, 6'd2);
    send_hand(60'h1, {2'd2, 6'd2, 11'd0, 60'h800000000000000});
    drain();
`endif

    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      d = {vec[i % 12][29:0], vec[(i + 5) % 12][59:30]};
      send(d);
    end
    ready_mode = 0;
    drain();

    ready_mode = 2;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    send(vec[8]);
    send(vec[9]);
    @(negedge Clk);
    check("full_out_valid", 79'(out_valid), 79'(1));
    check("full_in_ready", 79'(in_ready), 79'(0));
    #1 Rst = 1'b1;
    #1;
    check("midrst_out_valid", 79'(out_valid), 79'(0));
    check("midrst_in_ready", 79'(in_ready), 79'(0));
    sb.delete();
    km = 11'h5A5;
    sm = 6'h2B;
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst = 1'b0;
    ready_mode = 0;
    @(posedge Clk);
    #1;
    send_hand(60'h0, model(60'h0, 11'h5A5, 6'h2B));
    km = 11'h34A;
    sm = 6'h17;
    send(vec[3]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
